// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned RAM_ADDR_W = 5;
    localparam int unsigned RAM_DATA_W = 32;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

endpackage

// File: rtl/ram_arbiter_arb2_pick.sv
// Two-way grant picker: round-robin by default, fixed priority (master 0 wins)
// when RAM_ARB_FIXED_PRI_EN is defined.
module arb2_pick
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_valid,
    output logic sel
);

    assign gnt_valid = req0 | req1;

`ifdef RAM_ARB_FIXED_PRI_EN
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
    // Master 1 is only picked when master 0 is silent.
    assign sel = ~req0 & req1;
`else
    // On a tie the master that was not served last wins.
    assign sel = (req0 & req1) ? ~last_gnt : req1;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between two masters, one access per
// three cycles. Define RAM_ARB_FIXED_PRI_EN for fixed priority instead of round-robin.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_cen,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic              last_gnt_q, last_gnt_d;
    logic              cen_q, cen_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              gnt_valid;
    logic              pick_sel;

    arb2_pick u_pick (
        .req0      (m0_req),
        .req1      (m1_req),
        .last_gnt  (last_gnt_q),
        .gnt_valid (gnt_valid),
        .sel       (pick_sel)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_gnt_d = last_gnt_q;
        cen_d      = 1'b0;
        wen_d      = 1'b0;
        addr_d     = '0;
        din_d      = '0;
        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    // RAM pins are registered, so they are valid throughout ACCESS.
                    sel_d   = pick_sel;
                    cen_d   = 1'b1;
                    state_d = StAccess;
                    if (pick_sel) begin
                        wen_d  = m1_wr;
                        addr_d = m1_addr;
                        din_d  = (m1_wr == WR) ? m1_wdata : '0;
                    end else begin
                        wen_d  = m0_wr;
                        addr_d = m0_addr;
                        din_d  = (m0_wr == WR) ? m0_wdata : '0;
                    end
                end
            end
            StAccess: begin
                last_gnt_d = sel_q;
                state_d    = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            sel_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            cen_q      <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_gnt_q <= last_gnt_d;
            cen_q      <= cen_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
        end
    end

    assign ram_cen  = cen_q;
    assign ram_wen  = wen_q;
    assign ram_addr = addr_q;
    assign ram_din  = din_q;
    assign busy     = (state_q != StIdle);

    // RAM read data lands during RESP, so it is steered straight to the served master.
    assign m0_ack   = (state_q == StResp) && !sel_q;
    assign m1_ack   = (state_q == StResp) && sel_q;
    assign m0_rdata = m0_ack ? ram_dout : '0;
    assign m1_rdata = m1_ack ? ram_dout : '0;

endmodule
